// File: rtl/rgbi_capture.sv
// RGBI video capture: locks to hsync/vsync, packs two RGBI pixels per byte and
// streams one frame into a framebuffer through a 4-deep {addr,data} write FIFO.
module rgbi_capture #(
   parameter int H_ACTIVE_START = 116,
   parameter int H_PIXELS       = 256,
   parameter int PIXEL_DIV      = 2,
   parameter int V_ACTIVE_START = 33,
   parameter int V_LINES        = 480,
   parameter int ADDR_W         = 16
) (
   input  logic              master_clock,
   input  logic              reset_n,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              red,
   input  logic              green,
   input  logic              blue,
   input  logic              intensity,
   input  logic              arm,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              sync_error,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              wr_valid,
   input  logic              wr_ready
);
   localparam int HC_W  = $clog2(H_ACTIVE_START + 1);
   localparam int PIX_W = $clog2(H_PIXELS + 1);
   localparam int LN_W  = $clog2(V_LINES + 1);
   localparam int VC_W  = $clog2(V_ACTIVE_START + 1);
   localparam int PH_W  = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

   localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(H_ACTIVE_START - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_PIXELS - 1);
   localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(V_LINES - 1);
   localparam logic [VC_W-1:0]  VC_LAST  = VC_W'(V_ACTIVE_START - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PIXEL_DIV - 1);

   typedef enum logic [2:0] {IDLE, VWAIT, VSKIP, HWAIT, ACTIVE, HLINE, DRAIN} state_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_req_t;

   state_t            state, state_nxt;
   logic              hs_prev, vs_prev;
   logic [VC_W-1:0]   vcnt;
   logic [HC_W-1:0]   hcnt;
   logic [PH_W-1:0]   phase;
   logic [PIX_W-1:0]  pix;
   logic [LN_W-1:0]   line;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        hi_nib;
   wr_req_t           fifo_mem [4];
   logic [1:0]        rd_ptr, wr_ptr;
   logic [2:0]        fifo_cnt;

   logic [3:0] nib;
   logic       hs_rise, vs_rise, vs_fall, in_frame, abort;
   logic       sample, push, push_ok, pop, last_pix;

   assign nib      = {red, green, blue, intensity};
   assign hs_rise  = hsync & ~hs_prev;
   assign vs_rise  = vsync & ~vs_prev;
   assign vs_fall  = ~vsync & vs_prev;
   assign in_frame = (state == VSKIP) || (state == HWAIT) || (state == ACTIVE) || (state == HLINE);
   assign abort    = in_frame && vs_fall;
   assign sample   = (state == ACTIVE) && (phase == '0);
   assign push     = sample && pix[0];
   assign last_pix = (pix == PIX_LAST);
   assign pop      = (fifo_cnt != 3'd0) && wr_ready;
   // A full FIFO still accepts when the head leaves on the same edge.
   assign push_ok  = push && ((fifo_cnt != 3'd4) || pop);

   always_ff @(posedge master_clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (arm) state_nxt = VWAIT;
         VWAIT:  if (vs_rise) state_nxt = VSKIP;
         VSKIP:  if (abort) state_nxt = IDLE;
                 else if (hs_rise && vcnt == VC_LAST) state_nxt = HWAIT;
         HWAIT:  if (abort) state_nxt = IDLE;
                 else if (hcnt == HC_LAST) state_nxt = ACTIVE;
         ACTIVE: if (abort) state_nxt = IDLE;
                 else if (sample && last_pix) state_nxt = (line == LN_LAST) ? DRAIN : HLINE;
         HLINE:  if (abort) state_nxt = IDLE;
                 else if (hs_rise) state_nxt = HWAIT;
         DRAIN:  if (fifo_cnt == 3'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      wr_valid = (fifo_cnt != 3'd0);
      wr_addr  = fifo_mem[rd_ptr].addr;
      wr_data  = fifo_mem[rd_ptr].data;
      done     = (state == DRAIN) && pop && (fifo_cnt == 3'd1);
   end

   always_ff @(posedge master_clock or negedge reset_n) begin
      if (!reset_n) begin
         hs_prev    <= 1'b1;
         vs_prev    <= 1'b1;
         vcnt       <= '0;
         hcnt       <= '0;
         phase      <= '0;
         pix        <= '0;
         line       <= '0;
         addr       <= '0;
         hi_nib     <= '0;
         overflow   <= 1'b0;
         sync_error <= 1'b0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_cnt   <= '0;
         for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      end else begin
         hs_prev <= hsync;
         vs_prev <= vsync;
         if (state == IDLE && arm) begin
            overflow   <= 1'b0;
            sync_error <= 1'b0;
            line       <= '0;
            addr       <= '0;
         end
         if (abort) sync_error <= 1'b1;

         if (state == VWAIT)                vcnt <= '0;
         else if (state == VSKIP && hs_rise) vcnt <= vcnt + 1'b1;

         // hcnt equals the cycle index since the hsync rise that opened the line.
         if (hs_rise && (state == VSKIP || state == HLINE)) hcnt <= HC_W'(1);
         else if (state == HWAIT)                           hcnt <= hcnt + 1'b1;

         if (state == HWAIT) begin
            phase <= '0;
            pix   <= '0;
         end else if (state == ACTIVE) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            if (sample) begin
               pix <= pix + 1'b1;
               if (!pix[0]) hi_nib <= nib;
               if (last_pix) line <= line + 1'b1;
            end
         end

         if (push) addr <= addr + 1'b1;

         if (abort) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
         end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) begin
               fifo_mem[wr_ptr] <= '{addr: addr, data: {hi_nib, nib}};
               wr_ptr <= wr_ptr + 1'b1;
            end else if (push) begin
               overflow <= 1'b1;
            end
            case ({push_ok, pop})
               2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
               2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
               default: fifo_cnt <= fifo_cnt;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rgbi_capture.sv
// Randomized bench for rgbi_capture: a scaled-down video generator drives the DUT while a
// frame-level model predicts every framebuffer write, done pulse and sticky flag.
module tb_rgbi_capture;
   localparam int HAS = 12, HP = 16, PD = 2, VAS = 3, VL = 10, AW = 6;
   localparam int LINE_LEN = 60, HS_LOW = 8, NL = 16, SHORT_LINE = VAS + 5;

   logic master_clock = 1'b0, reset_n = 1'b0, hsync = 1'b1, vsync = 1'b1;
   logic red = 1'b0, green = 1'b0, blue = 1'b0, intensity = 1'b0, arm = 1'b0, wr_ready = 1'b0;
   logic busy, done, overflow, sync_error, wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   rgbi_capture #(
      .H_ACTIVE_START(HAS), .H_PIXELS(HP), .PIXEL_DIV(PD),
      .V_ACTIVE_START(VAS), .V_LINES(VL), .ADDR_W(AW)
   ) dut (
      .master_clock(master_clock), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue), .intensity(intensity), .arm(arm),
      .busy(busy), .done(done), .overflow(overflow), .sync_error(sync_error),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready)
   );

   always #5 master_clock = ~master_clock;

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   wr_t  mq[$];
   wr_t  lg[$];
   int   n_tests = 0, n_fail = 0;
   int   gl = 0, gc = 0, rst_hold = 0, bp_cnt = 0, done_cnt = 0;
   bit   arm_req = 0, arm_spam = 0, rnd_ready = 0, pattern = 0, short_inj = 0;
   bit   m_busy = 0, m_vwait = 0, m_cap = 0, m_drain = 0, m_ovf = 0, m_serr = 0;
   logic [3:0] m_hi = '0;
   logic vs_prev_m = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (line %0d cyc %0d)", tag, got, exp, gl, gc);
      end
   endtask

   task automatic tick();
      logic hs, vs, rdy;
      logic [3:0] px;
      int n, k;
      bit samp, pop, drain_exit, vs_fall, vs_rise;
      wr_t e;
      @(posedge master_clock); #1;
      hs = (gc < LINE_LEN - HS_LOW);
      vs = !((gl == NL-1 && gc >= 20) || (gl == 0 && gc < 20) ||
             (short_inj && gl == SHORT_LINE && gc >= 50 && gc < 58));
      n = gl - VAS;
      k = (gc - HAS) / PD;
      samp = (n >= 0 && n < VL && gc >= HAS && gc < HAS + HP*PD && (gc - HAS) % PD == 0);
      px = 4'($urandom_range(0, 15));
      if (pattern && samp) px = 4'((k + n) & 15);
      if (bp_cnt > 0) begin
         rdy = 1'b0;
         bp_cnt--;
      end else begin
         rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      reset_n  = (rst_hold == 0);
      hsync    = hs;
      vsync    = vs;
      {red, green, blue, intensity} = px;
      wr_ready = rdy;
      arm      = arm_req || (arm_spam && gc == 30 && n >= 0 && n < VL-1);
      arm_req  = 0;
      if (rst_hold > 0) begin
         mq.delete();
         {m_busy, m_vwait, m_cap, m_drain, m_ovf, m_serr} = '0;
      end

      @(negedge master_clock);
      check("valid", wr_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         check("addr", wr_addr, mq[0].a);
         check("data", wr_data, mq[0].d);
      end
      if (rst_hold > 0) begin
         check("rst_addr", wr_addr, 0);
         check("rst_data", wr_data, 0);
      end
      check("done", done, m_drain && mq.size() == 1 && rdy);
      check("busy", busy, m_busy);
      check("overflow", overflow, m_ovf);
      check("sync_error", sync_error, m_serr);
      if (wr_valid && rdy) begin
         e.a = wr_addr;
         e.d = wr_data;
         lg.push_back(e);
      end
      if (done) done_cnt++;

      vs_fall    = vs_prev_m && !vs;
      vs_rise    = !vs_prev_m && vs;
      pop        = (mq.size() != 0) && rdy;
      drain_exit = m_drain && mq.size() == 0;
      if (rst_hold > 0) begin
         rst_hold--;
      end else if (m_cap && vs_fall) begin
         mq.delete();
         m_serr = 1;
         m_cap  = 0;
         m_busy = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_cap && samp) begin
            if (k % 2 == 0) m_hi = px;
            else if (mq.size() < 4) begin
               e.a = AW'(n*(HP/2) + k/2);
               e.d = {m_hi, px};
               mq.push_back(e);
            end else m_ovf = 1;
            if (n == VL-1 && k == HP-1) begin
               m_cap   = 0;
               m_drain = 1;
            end
         end
         if (m_vwait && vs_rise) begin
            m_vwait = 0;
            m_cap   = 1;
         end
         if (arm && !m_busy) begin
            m_busy  = 1;
            m_vwait = 1;
            m_ovf   = 0;
            m_serr  = 0;
         end
         if (drain_exit) begin
            m_drain = 0;
            m_busy  = 0;
         end
      end
      vs_prev_m = vs;
      gc++;
      if (gc == LINE_LEN) begin
         gc = 0;
         gl = (gl + 1) % NL;
      end
   endtask

   task automatic run_to(input int l, input int c);
      while (!(gl == l && gc == c)) tick();
   endtask

   task automatic frame();
      done_cnt = 0;
      lg.delete();
      arm_req = 1;
      tick();
      run_to(14, 0);
   endtask

   initial begin
      int bad;
      rst_hold = 4;
      run_to(14, 0);
      check("idle_busy", busy, 0);

      // pattern frame, always ready, address wraps past 2^AW
      pattern = 1;
      frame();
      pattern = 0;
      check("f1_writes", lg.size(), VL*HP/2);
      check("f1_done", done_cnt, 1);
      check("f1_ovf", overflow, 0);
      if (lg.size() == VL*HP/2) begin
         check("f1_a0", lg[0].a, 0);
         check("f1_d0", lg[0].d, 8'h01);
         check("f1_d8", lg[8].d, 8'h12);
         check("f1_a64", lg[64].a, 0);
         check("f1_d64", lg[64].d, 8'h89);
         check("f1_alast", lg[79].a, 15);
         check("f1_dlast", lg[79].d, 8'h78);
      end

      // 20-cycle stall mid-line: exactly one byte lost
      arm_req = 1;
      done_cnt = 0;
      lg.delete();
      tick();
      run_to(VAS+2, 20);
      bp_cnt = 20;
      run_to(14, 0);
      check("bp_ovf", overflow, 1);
      check("bp_writes", lg.size(), VL*HP/2 - 1);
      check("bp_done", done_cnt, 1);

      rnd_ready = 1;
      frame();
      rnd_ready = 0;
      check("rr_done", done_cnt, 1);
      check("rr_serr", sync_error, 0);

      // vsync glitch during active line 5
      short_inj = 1;
      frame();
      short_inj = 0;
      check("sf_serr", sync_error, 1);
      check("sf_busy", busy, 0);
      check("sf_done", done_cnt, 0);
      check("sf_writes", lg.size(), 6*HP/2);
      frame();
      check("sf2_done", done_cnt, 1);
      check("sf2_serr", sync_error, 0);
      check("sf2_writes", lg.size(), VL*HP/2);

      // reset mid-active, then restart
      arm_req = 1;
      tick();
      run_to(VAS+3, 20);
      rst_hold = 3;
      run_to(VAS+3, 24);
      check("rs_busy", busy, 0);
      run_to(14, 0);
      frame();
      check("rs_done", done_cnt, 1);
      check("rs_writes", lg.size(), VL*HP/2);
      if (lg.size() != 0) check("rs_a0", lg[0].a, 0);

      // arm hammered while busy
      arm_spam = 1;
      frame();
      arm_spam = 0;
      check("as_done", done_cnt, 1);
      check("as_writes", lg.size(), VL*HP/2);
      bad = 0;
      foreach (lg[i]) if (lg[i].a != AW'(i)) bad++;
      check("as_order", bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
